pwm_duty_ramp_ctrl: RTL

//  Sequences the PWM duty-cycle register: sits between spi_peripheral's duty register (reg 4) and
//  pwm_peripheral's pwm_duty_cycle input. Slews the applied duty toward the SPI-written target
//  in programmable steps at a programmable rate, so motor/LED loads soft-start and soft-stop.

---
 rtl/pwm_duty_ramp_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - slews applied PWM duty toward the SPI-written target at a programmable rate
// Defining PWM_RAMP_DONE_EN adds the ramp_done completion pulse output.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  input  logic              ramp_en,
  input  logic [DIV_W-1:0]  ramp_div,
  input  logic [STEP_W-1:0] step_size,
  output logic [DUTY_W-1:0] duty_out,
`ifdef PWM_RAMP_DONE_EN
  output logic              busy,
  output logic              ramp_done
`else
  output logic              busy
`endif
);

  localparam int SW = DUTY_W + 1;

  typedef enum logic {S_IDLE, S_RAMP} state_e;

  state_e            state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] tgt_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic              ramp_en_q;
`ifdef PWM_RAMP_DONE_EN
  logic              done_q;
`endif

  logic [DUTY_W-1:0] tgt_eff;
  logic [SW-1:0]     step_ext;
  logic [SW-1:0]     sum_w;
  logic [SW-1:0]     diff_w;
  logic [DUTY_W-1:0] duty_d;
  logic              tick;

  // A target written this cycle takes priority so a coincident tick steps toward it.
  assign tgt_eff  = target_valid ? target_duty : tgt_q;
  assign step_ext = (step_size == '0) ? SW'(1) : SW'(step_size);
  assign sum_w    = {1'b0, duty_q} + step_ext;
  assign diff_w   = {1'b0, duty_q} - step_ext;
  assign tick     = (div_cnt_q >= ramp_div);

  // One extra bit catches wrap past either rail; both directions clamp at the target.
  always_comb begin
    duty_d = tgt_eff;
    if (tgt_eff > duty_q) begin
      if (sum_w < {1'b0, tgt_eff}) duty_d = sum_w[DUTY_W-1:0];
    end else begin
      if (!diff_w[DUTY_W] && (diff_w > {1'b0, tgt_eff})) duty_d = diff_w[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      duty_q    <= '0;
      tgt_q     <= '0;
      div_cnt_q <= '0;
      ramp_en_q <= 1'b0;
`ifdef PWM_RAMP_DONE_EN
      done_q    <= 1'b0;
`endif
    end else begin
      ramp_en_q <= ramp_en;
`ifdef PWM_RAMP_DONE_EN
      done_q    <= 1'b0;
`endif
      if (target_valid) tgt_q <= target_duty;

      if (!ramp_en) begin
        state_q <= S_IDLE;
        if (target_valid || (state_q == S_RAMP)) duty_q <= tgt_eff;
      end else if (state_q == S_IDLE) begin
        if ((target_valid || !ramp_en_q) && (tgt_eff != duty_q)) begin
          state_q   <= S_RAMP;
          div_cnt_q <= '0;
        end
      end else if (tgt_eff == duty_q) begin
        state_q <= S_IDLE;
      end else if (tick) begin
        duty_q    <= duty_d;
        div_cnt_q <= '0;
        if (duty_d == tgt_eff) begin
          state_q <= S_IDLE;
`ifdef PWM_RAMP_DONE_EN
          done_q  <= 1'b1;
`endif
        end
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign duty_out = duty_q;
  assign busy     = (state_q == S_RAMP);
`ifdef PWM_RAMP_DONE_EN
  assign ramp_done = done_q;
`endif

endmodule
